// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package arb_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_OWN_A, ST_OWN_B} arb_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arb_hold_timer.sv
// Counts contended ownership cycles and flags the cycle on which the owner must yield.
module arb_hold_timer #(
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   input  logic INC,
   output logic EXPIRE
);

   localparam logic [CNT_W-1:0] LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturate rather than wrap; only reachable when preemption is disabled.
   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (INC && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign EXPIRE = (MAX_HOLD != 0) && (cnt_q == LAST) && INC;

endmodule

// File: rtl/arb2_rr_sel.sv
// Two-requester round-robin arbiter with registered one-hot grants, mux select and
// bounded-hold preemption.
module arb2_rr_sel
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic REQ_A,
   input  logic REQ_B,
   output logic GNT_A,
   output logic GNT_B,
   output logic MUX_SEL,
   output logic BUSY,
   output logic PREEMPT
);

   arb_state_t state_q, state_d;
   logic       last_b_q, last_b_d;
   logic       mux_sel_q, mux_sel_d;
   logic       preempt_q, preempt_d;
   logic       gnt_a_q, gnt_b_q;
   logic       hold_inc, hold_clr, hold_expire;

   // A contended cycle: we own the resource and the other side is waiting.
   assign hold_inc = ((state_q == ST_OWN_A) && REQ_B) || ((state_q == ST_OWN_B) && REQ_A);
   assign hold_clr = (state_d != state_q) || !hold_inc;

   arb_hold_timer #(
      .CNT_W    (CNT_W),
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_timer (
      .CLK    (CLK),
      .RST    (RST),
      .CLR    (hold_clr),
      .INC    (hold_inc),
      .EXPIRE (hold_expire)
   );

   always_comb begin
      state_d   = state_q;
      preempt_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (REQ_A && REQ_B) begin
               state_d = last_b_q ? ST_OWN_A : ST_OWN_B;
            end else if (REQ_A) begin
               state_d = ST_OWN_A;
            end else if (REQ_B) begin
               state_d = ST_OWN_B;
            end
         end
         ST_OWN_A: begin
            if (!REQ_A) begin
               state_d = REQ_B ? ST_OWN_B : ST_IDLE;
            end else if (REQ_B && hold_expire) begin
               state_d   = ST_OWN_B;
               preempt_d = 1'b1;
            end
         end
         ST_OWN_B: begin
            if (!REQ_B) begin
               state_d = REQ_A ? ST_OWN_A : ST_IDLE;
            end else if (REQ_A && hold_expire) begin
               state_d   = ST_OWN_A;
               preempt_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pointer and select follow the owner; both hold their value while idle.
   always_comb begin
      last_b_d  = last_b_q;
      mux_sel_d = mux_sel_q;
      if (state_d == ST_OWN_A) begin
         last_b_d  = 1'b0;
         mux_sel_d = SEL_A;
      end else if (state_d == ST_OWN_B) begin
         last_b_d  = 1'b1;
         mux_sel_d = SEL_B;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         last_b_q  <= 1'b1;
         mux_sel_q <= SEL_A;
         preempt_q <= 1'b0;
         gnt_a_q   <= 1'b0;
         gnt_b_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         mux_sel_q <= mux_sel_d;
         preempt_q <= preempt_d;
         gnt_a_q   <= (state_d == ST_OWN_A);
         gnt_b_q   <= (state_d == ST_OWN_B);
      end
   end

   assign GNT_A   = gnt_a_q;
   assign GNT_B   = gnt_b_q;
   assign MUX_SEL = mux_sel_q;
   assign BUSY    = gnt_a_q | gnt_b_q;
   assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_arb2_rr_sel.sv
// Directed bench for arb2_rr_sel: one instance with MAX_HOLD=4, one with preemption off.
module tb_arb2_rr_sel;

   logic CLK = 1'b0;
   logic RST;
   logic REQ_A, REQ_B;
   logic GNT_A, GNT_B, MUX_SEL, BUSY, PREEMPT;
   logic GNT_A0, GNT_B0, MUX_SEL0, BUSY0, PREEMPT0;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 CLK = ~CLK;

   arb2_rr_sel #(
      .MAX_HOLD (4),
      .CNT_W    (4)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .REQ_A   (REQ_A),
      .REQ_B   (REQ_B),
      .GNT_A   (GNT_A),
      .GNT_B   (GNT_B),
      .MUX_SEL (MUX_SEL),
      .BUSY    (BUSY),
      .PREEMPT (PREEMPT)
   );

   arb2_rr_sel #(
      .MAX_HOLD (0),
      .CNT_W    (4)
   ) dut_nohold (
      .CLK     (CLK),
      .RST     (RST),
      .REQ_A   (REQ_A),
      .REQ_B   (REQ_B),
      .GNT_A   (GNT_A0),
      .GNT_B   (GNT_B0),
      .MUX_SEL (MUX_SEL0),
      .BUSY    (BUSY0),
      .PREEMPT (PREEMPT0)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic ga, input logic gb,
                             input logic ms, input logic pe);
      check({tag, ".gnt_a"},   GNT_A,   ga);
      check({tag, ".gnt_b"},   GNT_B,   gb);
      check({tag, ".mux_sel"}, MUX_SEL, ms);
      check({tag, ".busy"},    BUSY,    ga | gb);
      check({tag, ".preempt"}, PREEMPT, pe);
   endtask

   task automatic do_reset();
      RST   = 1'b1;
      REQ_A = 1'b0;
      REQ_B = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   initial begin
      logic exp_a;

      // Reset held with both requesting: outputs stay at reset values.
      RST   = 1'b1;
      REQ_A = 1'b1;
      REQ_B = 1'b1;
      tick();
      check_outs("rst_c1", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_outs("rst_c2", 1'b0, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      tick();
      check_outs("rst_release", 1'b1, 1'b0, 1'b0, 1'b0);

      // Single requester A for cycles 1-5.
      do_reset();
      REQ_A = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check_outs($sformatf("single_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      REQ_A = 1'b0;
      tick();
      check_outs("single_c6", 1'b0, 1'b0, 1'b0, 1'b0);

      // Handoff without bubble: A drops at cycle 3 while B waits.
      do_reset();
      REQ_A = 1'b1;
      REQ_B = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         check_outs($sformatf("handoff_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      REQ_A = 1'b0;
      tick();
      check_outs("handoff_c4", 1'b0, 1'b1, 1'b1, 1'b0);
      REQ_B = 1'b0;
      tick();
      check_outs("handoff_idle", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_outs("handoff_idle2", 1'b0, 1'b0, 1'b1, 1'b0);

      // Continuous contention: exact 4-cycle windows A,B,A,B with a preempt pulse per switch.
      do_reset();
      REQ_A = 1'b1;
      REQ_B = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         exp_a = (((c - 1) / 4) % 2) == 0;
         check_outs($sformatf("preempt_c%0d", c), exp_a, !exp_a, !exp_a,
                    (c == 5) || (c == 9) || (c == 13));
         check($sformatf("preempt_c%0d.onehot", c), GNT_A & GNT_B, 1'b0);
      end

      // Preemption disabled: A keeps the grant under contention.
      do_reset();
      REQ_A = 1'b1;
      REQ_B = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         check($sformatf("nohold_c%0d.gnt_a", c), GNT_A0, 1'b1);
         check($sformatf("nohold_c%0d.gnt_b", c), GNT_B0, 1'b0);
         check($sformatf("nohold_c%0d.preempt", c), PREEMPT0, 1'b0);
      end

      // Reset while B owns: everything returns to reset values, pointer favours A again.
      do_reset();
      REQ_B = 1'b1;
      tick();
      check_outs("midrst_own_b", 1'b0, 1'b1, 1'b1, 1'b0);
      REQ_A = 1'b1;
      RST   = 1'b1;
      tick();
      check_outs("midrst_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      tick();
      check_outs("midrst_after", 1'b1, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/arb2_rr_sel.md
Name: arb2_rr_sel

Overview:
- Two-requester round-robin arbiter that shares a single datapath resource (memory port, bus, register-file write port) between requester A and requester B.
- Drives the select line of the downstream 2:1 select mux.
- Registered one-hot grants, with optional bounded-hold preemption so neither requester can starve the other.
- Sits between the requesting units and the shared resource's input mux.

Parameters:
- MAX_HOLD, 4: number of contended grant cycles before the owner is preempted. 0 disables preemption.
- CNT_W, 4: hold counter width. Requires MAX_HOLD < 2**CNT_W.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_A  input  1  requester A wants the resource; held high for the whole transaction.
- REQ_B  input  1  requester B wants the resource; held high for the whole transaction.
- GNT_A  output  1  A owns the resource this cycle.
- GNT_B  output  1  B owns the resource this cycle.
- MUX_SEL  output  1  select to downstream mux: 0 = A path, 1 = B path.
- BUSY  output  1  high whenever either grant is high.
- PREEMPT  output  1  one-cycle pulse on the cycle a grant is taken by preemption.

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high.
- Reset values: state IDLE, GNT_A=0, GNT_B=0, MUX_SEL=0, BUSY=0, PREEMPT=0, hold_cnt=0, last_b=1 (A wins the first tie).
- All outputs are registered. Latency from request to grant is 1 cycle.
- Grants are never both high (one-hot or zero). MUX_SEL always equals the current owner; in IDLE it holds its last value (no toggling).
- IDLE:
  - REQ_A & REQ_B -> grant the requester not last served (last_b=1 -> A).
  - Only one request -> grant that requester.
  - No requests -> stay in IDLE.
- OWN_A (OWN_B is symmetric):
  - REQ_A=0 & REQ_B=1 -> OWN_B directly at the next edge, no idle bubble.
  - REQ_A=0 & REQ_B=0 -> IDLE.
  - REQ_A=1 & REQ_B=1 & MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1 -> OWN_B, PREEMPT=1 for that cycle.
  - Otherwise stay in OWN_A.
- hold_cnt:
  - Increments on each owned cycle while the other requester is asserting.
  - Clears when the other requester deasserts.
  - Clears on every ownership change.
  - Never wraps; the preempt transition happens first.
- last_b: updated on every grant: 1 when B is granted, 0 when A is granted.
- Simultaneous events: owner release and other-side request in the same cycle is a normal handoff, PREEMPT=0.
- Owner drops and re-raises its request: a one-cycle low is treated as a release. If the other side is requesting, the other side wins.
- Reset mid-operation: all outputs return to reset values at the next edge, regardless of requests; the pointer resets too.
- PREEMPT is never high in the same cycle as RST or in IDLE.

Decomposition:
- Shared package arb_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_OWN_A, ST_OWN_B} arb_state_t;
  - localparams SEL_A=1'b0 and SEL_B=1'b1.
- One sub-module, arb_hold_timer:
  - Parameterised CNT_W/MAX_HOLD counter.
  - Inputs: CLK, RST, CLR, INC.
  - Output: EXPIRE, combinational, = (MAX_HOLD!=0) & (cnt==MAX_HOLD-1) & INC.
- Top level holds the FSM, the last_b pointer and the output registers.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ_A=REQ_B=1 -> GNT_A=GNT_B=0, MUX_SEL=0, BUSY=0, PREEMPT=0 throughout. RST=0 -> GNT_A=1 one cycle later.
- Single requester: REQ_A=1 at cycle 0, REQ_A=0 at cycle 5 -> GNT_A=1 cycles 1-5, GNT_A=0 at cycle 6, MUX_SEL=0 throughout.
- Handoff without bubble: REQ_A=REQ_B=1 from reset, A drops at cycle 3 -> GNT_A cycles 1-3, GNT_B=1 and MUX_SEL=1 at cycle 4, PREEMPT=0. MUX_SEL stays 1 after B releases.
- Preemption, MAX_HOLD=4: REQ_A and REQ_B held high continuously -> grants alternate in exact 4-cycle windows A,B,A,B; PREEMPT pulses once at each switch; never both grants high.
- Preemption disabled, MAX_HOLD=0: REQ_A and REQ_B high for 20 cycles -> GNT_A held all 20 cycles, PREEMPT=0.
- Reset mid-grant: B owns with MUX_SEL=1, RST pulsed 1 cycle -> next edge all outputs at reset values. With both requesting afterwards, A is granted first.
